// File: rtl/hit_event_queue_if.sv
// Bundle between hit_event_queue and its producer/consumer: detector decisions in,
// FWFT strike FIFO head and status out.
interface hit_event_queue_if #(
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 13
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  sample;
    logic [2:0]            note_code;
    logic                  rd_en;
    logic                  clr_ovf;
    logic [3+TS_WIDTH-1:0] rd_data;
    logic                  empty;
    logic [CW-1:0]         count;
    logic                  overflow;

    modport master (
        output sample, note_code, rd_en, clr_ovf,
        input  rd_data, empty, count, overflow
    );

    modport slave (
        input  sample, note_code, rd_en, clr_ovf,
        output rd_data, empty, count, overflow
    );
endinterface

// File: rtl/hit_event_queue.sv
// Debounces tone-detector decisions into timestamped strikes and queues them in a FWFT FIFO.
// Optional irq output enabled by defining HIT_EVENT_IRQ_EN.
//   state    | meaning
//   QUIET    | idle, waiting for a non-silent decision
//   CONFIRM  | counting identical decisions toward CONFIRM_N
//   HOLD     | strike emitted, note still sounding
//   COOLDOWN | refractory period after release, decisions ignored
module hit_event_queue #(
    parameter int CONFIRM_N  = 2,
    parameter int COOLDOWN_N = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 13
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    hit_event_queue_if.slave bus
`ifdef HIT_EVENT_IRQ_EN
    ,
    input  logic             irq_en_i,
    output logic             irq_o
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 3 + TS_WIDTH;
    localparam logic [3:0] CONFIRM_V = 4'(CONFIRM_N);
    localparam logic [3:0] COOL_V    = 4'(COOLDOWN_N);

    typedef enum logic [1:0] {QUIET, CONFIRM, HOLD, COOLDOWN} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cand_q, cand_d;
    logic [3:0]            run_q, run_d;
    logic [3:0]            cool_q, cool_d;
    logic [TS_WIDTH-1:0]   ts_q;
    logic [PW-1:0]         wr_q, rd_q;
    logic [EW-1:0]         rd_data_q;
    logic                  overflow_q;
    logic [EW-1:0]         mem_q [FIFO_DEPTH];

    logic [2:0]            note;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  push_ok;
    logic                  drop;
    logic [PW-1:0]         count;
    logic [PW-1:0]         wr_next, rd_next;
    logic [EW-1:0]         push_data;

    // Codes 5-7 are not valid bars and count as silence.
    assign note = (bus.note_code > 3'd4) ? 3'd0 : bus.note_code;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        run_d   = run_q;
        cool_d  = cool_q;
        push    = 1'b0;
        if (bus.sample) begin
            unique case (state_q)
                QUIET: begin
                    if (note != 3'd0) begin
                        cand_d = note;
                        run_d  = 4'd1;
                        if (CONFIRM_N == 1) begin
                            push    = 1'b1;
                            state_d = HOLD;
                        end else begin
                            state_d = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (note == 3'd0) begin
                        state_d = QUIET;
                    end else if (note == cand_q) begin
                        run_d = run_q + 4'd1;
                        if (run_q + 4'd1 == CONFIRM_V) begin
                            push    = 1'b1;
                            state_d = HOLD;
                        end
                    end else begin
                        cand_d = note;
                        run_d  = 4'd1;
                    end
                end
                HOLD: begin
                    if (note == 3'd0) begin
                        cool_d  = COOL_V;
                        state_d = (COOLDOWN_N == 0) ? QUIET : COOLDOWN;
                    end else if (note != cand_q) begin
                        cand_d = note;
                        run_d  = 4'd1;
                        if (CONFIRM_N == 1) push = 1'b1;
                        else                state_d = CONFIRM;
                    end
                end
                COOLDOWN: begin
                    cool_d = (cool_q == 4'd0) ? 4'd0 : cool_q - 4'd1;
                    if (cool_q <= 4'd1) state_d = QUIET;
                end
                default: state_d = QUIET;
            endcase
        end
    end

    assign push_data = {cand_d, ts_q};
    assign count     = wr_q - rd_q;
    assign empty     = (wr_q == rd_q);
    assign full      = (count == PW'(FIFO_DEPTH));
    assign pop       = bus.rd_en & ~empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign push_ok   = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign wr_next   = wr_q + PW'(push_ok);
    assign rd_next   = rd_q + PW'(pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= QUIET;
            cand_q     <= '0;
            run_q      <= '0;
            cool_q     <= '0;
            ts_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            run_q   <= run_d;
            cool_q  <= cool_d;
            if (bus.sample) ts_q <= ts_q + TS_WIDTH'(1);
            wr_q <= wr_next;
            rd_q <= rd_next;
            // Registered head; when the new head is the entry being written this edge, bypass it.
            if (wr_next != rd_next)
                rd_data_q <= (rd_next == wr_q) ? push_data : mem_q[rd_next[AW-1:0]];
            if (drop)             overflow_q <= 1'b1;
            else if (bus.clr_ovf) overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= push_data;
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.empty    = empty;
    assign bus.count    = count;
    assign bus.overflow = overflow_q;

`ifdef HIT_EVENT_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) irq_q <= 1'b0;
        else          irq_q <= irq_en_i & ~empty;
    end
    assign irq_o = irq_q;
`endif
endmodule

// File: tb/tb_hit_event_queue.sv
// Directed plus randomized bench for hit_event_queue against a queue-based strike model.
module tb_hit_event_queue;
    localparam int CN = 2;
    localparam int CD = 3;
    localparam int DEPTH = 4;
    localparam int TSW = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hit_event_queue_if #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) bus ();

`ifdef HIT_EVENT_IRQ_EN
    logic irq_en = 1'b0;
    logic irq;
    bit   exp_irq;
`endif

    hit_event_queue #(.CONFIRM_N(CN), .COOLDOWN_N(CD), .FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
`ifdef HIT_EVENT_IRQ_EN
        ,
        .irq_en_i(irq_en),
        .irq_o   (irq)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference: strike rules on plain integers, FIFO as a queue.
    logic [15:0] q[$];
    int  m_cur, m_run, m_cool, m_ts;
    bit  m_struck, m_ovf;
    logic [15:0] exp_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cur = 0; m_run = 0; m_cool = 0; m_ts = 0;
        m_struck = 0; m_ovf = 0; exp_rd = '0;
`ifdef HIT_EVENT_IRQ_EN
        exp_irq = 0;
`endif
    endtask

    task automatic model_step(input bit s, input logic [2:0] c, input bit r, input bit clr);
        bit push = 0;
        bit pop  = r && (q.size() > 0);
        bit drop;
        int n;
        logic [2:0] cb;
        logic [15:0] pd = '0;
`ifdef HIT_EVENT_IRQ_EN
        exp_irq = irq_en && (q.size() > 0);
`endif
        if (s) begin
            n = (c > 4) ? 0 : int'(c);
            if (m_cool > 0) begin
                m_cool--;
            end else if (n == 0) begin
                if (m_struck) m_cool = CD;
                m_cur = 0; m_run = 0; m_struck = 0;
            end else if (n == m_cur) begin
                m_run++;
                if (!m_struck && m_run == CN) begin push = 1; m_struck = 1; end
            end else begin
                m_cur = n; m_run = 1; m_struck = 0;
                if (m_run == CN) begin push = 1; m_struck = 1; end
            end
            cb = m_cur[2:0];
            pd = {cb, m_ts[12:0]};
            m_ts = (m_ts + 1) % (1 << TSW);
        end
        drop = push && (q.size() >= DEPTH) && !pop;
        if (pop) void'(q.pop_front());
        if (push && !drop) q.push_back(pd);
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (q.size() > 0) exp_rd = q[0];
    endtask

    task automatic compare_all();
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("rd_data", 32'(bus.rd_data), 32'(exp_rd));
`ifdef HIT_EVENT_IRQ_EN
        chk("irq", 32'(irq), 32'(exp_irq));
`endif
    endtask

    task automatic step(input bit s, input logic [2:0] c, input bit r, input bit clr);
        @(negedge clk);
        bus.sample = s; bus.note_code = c; bus.rd_en = r; bus.clr_ovf = clr;
        @(posedge clk);
        #1;
        model_step(s, c, r, clr);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.sample = 0; bus.note_code = 0; bus.rd_en = 0; bus.clr_ovf = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_all();
    endtask

    task automatic codes(input logic [2:0] seq[$]);
        foreach (seq[i]) step(1, seq[i], 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, 0);
    endtask

    initial begin
        logic [2:0] cur_code;
        bus.sample = 0; bus.note_code = 0; bus.rd_en = 0; bus.clr_ovf = 0;
`ifdef HIT_EVENT_IRQ_EN
        irq_en = 1'b1;
`endif
        model_reset();
        #12;
        chk("reset_empty", 32'(bus.empty), 32'd1);
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
        do_reset();

        // basic strike
        step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        chk("basic_empty_after_confirm", 32'(bus.empty), 32'd0);
        step(1, 1, 0, 0); step(1, 0, 0, 0);
        chk("basic_count", 32'(bus.count), 32'd1);
        chk("basic_entry", 32'(bus.rd_data), {16'd0, 3'd1, 13'd2});
        drain();

        // noise rejection
        do_reset();
        codes('{3'd3, 3'd0, 3'd3, 3'd0, 3'd6, 3'd6});
        chk("noise_count", 32'(bus.count), 32'd0);

        // refractory period
        do_reset();
        codes('{3'd2, 3'd2, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2});
        chk("refr_count", 32'(bus.count), 32'd2);
        chk("refr_first", 32'(bus.rd_data), {16'd0, 3'd2, 13'd1});
        step(0, 0, 1, 0);
        chk("refr_second", 32'(bus.rd_data), {16'd0, 3'd2, 13'd7});
        drain();

        // legato
        do_reset();
        codes('{3'd1, 3'd1, 3'd4, 3'd4});
        chk("legato_first", 32'(bus.rd_data), {16'd0, 3'd1, 13'd1});
        step(0, 0, 1, 0);
        chk("legato_second", 32'(bus.rd_data), {16'd0, 3'd4, 13'd3});
        drain();

        // overflow
        do_reset();
        codes('{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd1, 3'd1});
        chk("ovf_count", 32'(bus.count), 32'd4);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        step(0, 0, 1, 0);
        chk("ovf_pop_count", 32'(bus.count), 32'd3);
        chk("ovf_pop_head", 32'(bus.rd_data), {16'd0, 3'd2, 13'd3});
        step(0, 0, 0, 1);
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);
        step(1, 2, 0, 0); step(1, 2, 0, 0);
        chk("ovf_refull", 32'(bus.count), 32'd4);
        step(1, 3, 0, 0); step(1, 3, 1, 0);
        chk("full_pushpop_count", 32'(bus.count), 32'd4);
        chk("full_pushpop_ovf", 32'(bus.overflow), 32'd0);
        drain();

        // async reset mid-operation
        do_reset();
        codes('{3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1});
        chk("pre_reset_count", 32'(bus.count), 32'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_empty", 32'(bus.empty), 32'd1);
        chk("async_count", 32'(bus.count), 32'd0);
        chk("async_ovf", 32'(bus.overflow), 32'd0);
        model_reset();
        bus.sample = 0; bus.rd_en = 0; bus.clr_ovf = 0;
        @(negedge clk);
        rst_n = 1'b1;
        codes('{3'd1, 3'd1});
        chk("post_reset_entry", 32'(bus.rd_data), {16'd0, 3'd1, 13'd1});
        drain();

        // randomized against the model
        cur_code = 3'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) cur_code = 3'($urandom_range(0, 7));
`ifdef HIT_EVENT_IRQ_EN
            if ($urandom_range(0, 19) == 0) irq_en = ~irq_en;
`endif
            step(($urandom_range(0, 9) < 7), cur_code,
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hit_event_queue.md
Name: hit_event_queue

Overview:
- Sits directly downstream of the tone detector. Consumes its windowed decision (3-bit code: 0 = silence, 1–4 = bar) plus a one-cycle strobe marking each new decision.
- Debounces decisions into discrete strike events and enforces a refractory period after each note releases.
- Timestamps each strike with a sample counter and buffers strikes in a first-word-fall-through FIFO, which the bus/register layer drains for software.

Parameters:
- CONFIRM_N, 2: consecutive identical non-silent decisions needed to emit a strike (legal range 1–15).
- COOLDOWN_N, 3: decisions ignored after a note releases to silence (legal range 0–15).
- FIFO_DEPTH, 8: entry count; must be a power of two, at least 2.
- TS_WIDTH, 13: timestamp width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sample  in  1  one-cycle strobe: note_code valid
- note_code  in  3  detector decision; codes 5–7 are treated as silence
- rd_en  in  1  pop head entry
- clr_ovf  in  1  clear sticky overflow
- rd_data  out  3+TS_WIDTH  head entry {note[2:0], ts}
- empty  out  1  FIFO empty
- count  out  $clog2(FIFO_DEPTH)+1  occupancy
- overflow  out  1  sticky: a strike was dropped

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to QUIET; cand = 0, run = 0, cool = 0, ts = 0.
  - FIFO pointers = 0, so empty = 1 and count = 0.
  - overflow = 0; rd_data = 0.
- Timestamp: ts increments by 1 (mod 2^TS_WIDTH) on every sample strobe. A strike captures the pre-increment value of the confirming sample.
- FSM advances only on sample strobes. With sample = 0, all state holds.
- QUIET:
  - note != 0: cand <= note, run <= 1.
    - If CONFIRM_N == 1, emit and go to HOLD.
    - Otherwise go to CONFIRM.
  - silence: stay in QUIET.
- CONFIRM:
  - note == cand: run++. When run reaches CONFIRM_N, emit and go to HOLD.
  - Different non-zero note: cand <= note, run <= 1, stay in CONFIRM.
  - silence: go to QUIET.
- HOLD:
  - note == cand: stay; no re-emit, however long the note lasts.
  - silence: cool <= COOLDOWN_N and go to COOLDOWN; if COOLDOWN_N == 0, go straight to QUIET.
  - Different non-zero note (legato strike of another bar): cand <= note, run <= 1, go to CONFIRM; if CONFIRM_N == 1, emit immediately and stay in HOLD.
- COOLDOWN:
  - Every sample decrements cool, whatever its note value; the note value is ignored.
  - When cool reaches 0, go to QUIET. The sample that causes this transition is itself ignored.
- Emit: push {cand, ts} on the same clock edge the confirming sample is accepted.
  - empty deasserts and count updates on the following cycle.
  - If the FIFO is full with no simultaneous pop, the push is dropped and overflow <= 1.
- FIFO:
  - FWFT: rd_data always shows the head entry when empty = 0.
  - rd_en while empty is ignored; rd_data is held.
  - Push and pop on the same cycle: both take effect and count is unchanged. This also applies when full, so the push is accepted and overflow is not set.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: cleared by clr_ovf. If clr_ovf and a dropped push occur on the same cycle, set wins.
- Latency: sample edge to entry visible = 1 cycle.

Optional Feature:
- Macro: HIT_EVENT_IRQ_EN.
- When defined, adds input irq_en (1 bit) and output irq (1 bit).
  - irq is registered and equals irq_en & ~empty, delayed by 1 cycle; reset value 0.
  - irq drops the cycle after the FIFO drains or irq_en falls.
- When not defined, neither port exists and the behaviour is otherwise identical.

Test Plan:
(Settings: CONFIRM_N = 2, COOLDOWN_N = 3, FIFO_DEPTH = 4; ts starts at 0 after reset.)
1. Basic strike: sample codes 0,1,1,1,0 → exactly one entry {1, ts = 2}; empty falls 1 cycle after the third sample.
2. Noise rejection: codes 3,0,3,0,6,6 → no entries; count stays 0.
3. Refractory period: codes 2,2,0,2,2,2,2,2 → entries {2,1} and {2,7} only. The samples at ts 3–5 are ignored during COOLDOWN.
4. Legato strike: codes 1,1,4,4 → entries {1,1} then {4,3}, in that order.
5. Overflow: 5 strikes, no reads → count = 4, overflow = 1, 5th strike dropped.
   - rd_en pops the first strike's entry; count becomes 3.
   - clr_ovf clears overflow.
   - A push and pop on the same cycle while full keeps count at 4 with overflow at 0.
6. Reset mid-operation: codes 1 (state is CONFIRM) with 2 entries queued, then assert reset asynchronously between edges → empty = 1, count = 0, overflow = 0 immediately.
   - After release, codes 1,1 → entry {1,1}, confirming ts restarted from 0.
